// File: rtl/score_pkg.sv
// Shared types, widths and default weights for the gameplay scoring controller.
package score_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SCORE_W   = 16;
    localparam int unsigned COMBO_W   = 10;
    localparam int unsigned CNT_W     = 4;

    localparam int unsigned HIT_PTS_DEF    = 10;
    localparam int unsigned MISS_PTS_DEF   = 5;
    localparam int unsigned COMBO_STEP_DEF = 10;
    localparam int unsigned MAX_MULT_DEF   = 4;
    localparam int unsigned COMBO_MAX_DEF  = 999;

    typedef enum logic [1:0] {
        PhIdle   = 2'd0,
        PhPlay   = 2'd1,
        PhCommit = 2'd2,
        PhDone   = 2'd3
    } phase_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lane_evt_cnt.sv
// Per-lane saturating hit/miss counters with a snapshot copy for the commit sequencer.
module lane_evt_cnt
    import score_pkg::*;
(
    input  logic             Clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             snap,
    input  logic             count_en,
    input  logic             hit,
    input  logic             miss,
    output logic [CNT_W-1:0] hit_snap,
    output logic [CNT_W-1:0] miss_snap
);

    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] hit_snap_q, hit_snap_d, miss_snap_q, miss_snap_d;
    logic [CNT_W-1:0] hit_base, miss_base;

    // A snapshot opens a fresh window; a pulse in the same cycle counts into it.
    always_comb begin
        hit_base    = snap ? '0 : hit_cnt_q;
        miss_base   = snap ? '0 : miss_cnt_q;
        hit_cnt_d   = (count_en && hit)  ? sat_inc(hit_base)  : hit_base;
        miss_cnt_d  = (count_en && miss) ? sat_inc(miss_base) : miss_base;
        hit_snap_d  = snap ? hit_cnt_q  : hit_snap_q;
        miss_snap_d = snap ? miss_cnt_q : miss_snap_q;
        if (clear) begin
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            hit_snap_d  = '0;
            miss_snap_d = '0;
        end
    end

    // Counter and snapshot registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            hit_snap_q  <= '0;
            miss_snap_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            hit_snap_q  <= hit_snap_d;
            miss_snap_q <= miss_snap_d;
        end
    end

    assign hit_snap  = hit_snap_q;
    assign miss_snap = miss_snap_q;

endmodule

// File: rtl/score_ctrl.sv
// Game-phase FSM and per-lane weighted score/combo sequencer for the HUD.
module score_ctrl
    import score_pkg::*;
#(
    parameter int unsigned HIT_PTS    = HIT_PTS_DEF,
    parameter int unsigned MISS_PTS   = MISS_PTS_DEF,
    parameter int unsigned COMBO_STEP = COMBO_STEP_DEF,
    parameter int unsigned MAX_MULT   = MAX_MULT_DEF,
    parameter int unsigned COMBO_MAX  = COMBO_MAX_DEF
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 frame_clk,
    input  logic                 start,
    input  logic                 song_end,
    input  logic [NUM_LANES-1:0] hit_evt,
    input  logic [NUM_LANES-1:0] miss_evt,
    output logic [SCORE_W-1:0]   score,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   max_combo,
    output logic [2:0]           mult,
    output logic                 busy,
    output logic [1:0]           phase
);

    localparam logic [COMBO_W:0]   ComboMaxExt = (COMBO_W+1)'(COMBO_MAX);
    localparam logic [COMBO_W-1:0] ComboMax    = COMBO_W'(COMBO_MAX);
    localparam logic [COMBO_W-1:0] ComboStep   = COMBO_W'(COMBO_STEP);
    localparam logic [COMBO_W-1:0] MultCapDiv  = COMBO_W'(MAX_MULT - 1);
    localparam logic [2:0]         MaxMult     = 3'(MAX_MULT);

    phase_t               state_q, state_d;
    logic                 frame_clk_q, fe;
    logic                 pending_fe_q, pending_fe_d;
    logic                 end_pending_q, end_pending_d;
    logic                 end_req_q, end_req_d;
    logic [1:0]           lane_idx_q, lane_idx_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d, max_combo_q, max_combo_d;
    logic [2:0]           mult_q, mult_d;
    logic                 clear, snap, count_en;

    logic [CNT_W-1:0]     hit_snap  [NUM_LANES];
    logic [CNT_W-1:0]     miss_snap [NUM_LANES];

    assign fe       = frame_clk & ~frame_clk_q;
    assign count_en = (state_q == PhPlay) || (state_q == PhCommit);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_evt_cnt u_lane (
            .Clk       (Clk),
            .reset     (reset),
            .clear     (clear),
            .snap      (snap),
            .count_en  (count_en),
            .hit       (hit_evt[i]),
            .miss      (miss_evt[i]),
            .hit_snap  (hit_snap[i]),
            .miss_snap (miss_snap[i])
        );
    end

    logic [CNT_W-1:0]   lane_hits, lane_miss;
    logic [18:0]        pts, pen;
    logic signed [18:0] s_sum;
    logic [SCORE_W-1:0] score_new;
    logic [COMBO_W:0]   combo_sum;
    logic [COMBO_W-1:0] combo_new, mult_div, max_new;
    logic [2:0]         mult_new;

    // Weighted, clamped update for the lane currently being committed.
    always_comb begin
        lane_hits = hit_snap[lane_idx_q];
        lane_miss = miss_snap[lane_idx_q];
        pts       = 19'(lane_hits) * 19'(HIT_PTS) * 19'(mult_q);
        pen       = 19'(lane_miss) * 19'(MISS_PTS);
        s_sum     = $signed({3'b000, score_q}) + $signed(pts) - $signed(pen);
        if (s_sum < 0) begin
            score_new = '0;
        end else if (s_sum > 19'sd65535) begin
            score_new = '1;
        end else begin
            score_new = s_sum[SCORE_W-1:0];
        end
        combo_sum = {1'b0, combo_q} + {{(COMBO_W+1-CNT_W){1'b0}}, lane_hits};
        if (lane_miss != '0) begin
            combo_new = '0;
        end else if (combo_sum > ComboMaxExt) begin
            combo_new = ComboMax;
        end else begin
            combo_new = combo_sum[COMBO_W-1:0];
        end
        max_new  = (combo_new > max_combo_q) ? combo_new : max_combo_q;
        mult_div = combo_new / ComboStep;
        mult_new = (mult_div >= MultCapDiv) ? MaxMult : 3'(mult_div + 1'b1);
    end

    // Phase sequencing: window snapshots, four-cycle commit, restart/abort on start.
    always_comb begin
        state_d       = state_q;
        pending_fe_d  = pending_fe_q;
        end_pending_d = end_pending_q;
        end_req_d     = end_req_q;
        lane_idx_d    = lane_idx_q;
        score_d       = score_q;
        combo_d       = combo_q;
        max_combo_d   = max_combo_q;
        mult_d        = mult_q;
        clear         = 1'b0;
        snap          = 1'b0;
        if (start) begin
            clear         = 1'b1;
            state_d       = PhPlay;
            pending_fe_d  = 1'b0;
            end_pending_d = 1'b0;
            end_req_d     = 1'b0;
            lane_idx_d    = '0;
            score_d       = '0;
            combo_d       = '0;
            max_combo_d   = '0;
            mult_d        = 3'd1;
        end else begin
            unique case (state_q)
                PhIdle, PhDone: begin
                    snap = fe;
                end
                PhPlay: begin
                    if (fe || pending_fe_q || song_end) begin
                        snap          = 1'b1;
                        pending_fe_d  = 1'b0;
                        lane_idx_d    = '0;
                        state_d       = PhCommit;
                        end_pending_d = song_end;
                    end
                end
                PhCommit: begin
                    if (fe) pending_fe_d = 1'b1;
                    // A song end seen mid-commit still gets its own final snapshot.
                    if (song_end) end_req_d = 1'b1;
                    score_d     = score_new;
                    combo_d     = combo_new;
                    max_combo_d = max_new;
                    mult_d      = mult_new;
                    lane_idx_d  = lane_idx_q + 2'd1;
                    if (lane_idx_q == 2'(NUM_LANES - 1)) begin
                        if (end_pending_q) begin
                            state_d = PhDone;
                        end else if (pending_fe_d || end_req_d) begin
                            snap          = 1'b1;
                            end_pending_d = end_req_d;
                            end_req_d     = 1'b0;
                            pending_fe_d  = 1'b0;
                            lane_idx_d    = '0;
                        end else begin
                            state_d = PhPlay;
                        end
                    end
                end
                default: state_d = PhIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q       <= PhIdle;
            frame_clk_q   <= 1'b0;
            pending_fe_q  <= 1'b0;
            end_pending_q <= 1'b0;
            end_req_q     <= 1'b0;
            lane_idx_q    <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            max_combo_q   <= '0;
            mult_q        <= 3'd1;
        end else begin
            state_q       <= state_d;
            frame_clk_q   <= frame_clk;
            pending_fe_q  <= pending_fe_d;
            end_pending_q <= end_pending_d;
            end_req_q     <= end_req_d;
            lane_idx_q    <= lane_idx_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            max_combo_q   <= max_combo_d;
            mult_q        <= mult_d;
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign mult      = mult_q;
    assign busy      = (state_q == PhCommit);
    assign phase     = state_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed plus randomized check of score_ctrl against a behavioural scoring model.
module tb_score_ctrl;

    localparam int HitPts = 10, MissPts = 5, ComboStep = 10, MaxMult = 4, ComboMax = 999;

    logic       Clk = 1'b0;
    logic       reset = 1'b1, frame_clk = 1'b0, start = 1'b0, song_end = 1'b0;
    logic [3:0] hit_evt = '0, miss_evt = '0;
    logic [15:0] score;
    logic [9:0]  combo, max_combo;
    logic [2:0]  mult;
    logic        busy;
    logic [1:0]  phase;

    score_ctrl dut (
        .Clk       (Clk),
        .reset     (reset),
        .frame_clk (frame_clk),
        .start     (start),
        .song_end  (song_end),
        .hit_evt   (hit_evt),
        .miss_evt  (miss_evt),
        .score     (score),
        .combo     (combo),
        .max_combo (max_combo),
        .mult      (mult),
        .busy      (busy),
        .phase     (phase)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    // Model state: 0 idle, 1 play, 2 commit, 3 done.
    int m_phase, m_score, m_combo, m_max, m_mult, m_lane;
    bit m_pfe, m_endp, m_endreq, m_fprev;
    int live_h[4], live_m[4], snap_h[4], snap_m[4];

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_score = 0; m_combo = 0; m_max = 0; m_mult = 1; m_lane = 0;
        m_pfe = 0; m_endp = 0; m_endreq = 0;
        for (int l = 0; l < 4; l++) begin
            live_h[l] = 0; live_m[l] = 0; snap_h[l] = 0; snap_m[l] = 0;
        end
    endfunction

    function automatic void commit_lane(int l);
        int s;
        s = m_score + snap_h[l] * HitPts * m_mult - snap_m[l] * MissPts;
        m_score = (s < 0) ? 0 : (s > 65535) ? 65535 : s;
        if (snap_m[l] > 0) m_combo = 0;
        else m_combo = (m_combo + snap_h[l] > ComboMax) ? ComboMax : m_combo + snap_h[l];
        if (m_combo > m_max) m_max = m_combo;
        m_mult = (1 + m_combo / ComboStep > MaxMult) ? MaxMult : 1 + m_combo / ComboStep;
    endfunction

    // Advance the model by one clock using the inputs that were applied for it.
    function automatic void model_step();
        bit fe, take, counting;
        fe = frame_clk && !m_fprev;
        if (reset) begin
            model_clear(); m_phase = 0; m_fprev = 0;
            return;
        end
        m_fprev = frame_clk;
        if (start) begin
            model_clear(); m_phase = 1;
            return;
        end
        counting = (m_phase == 1) || (m_phase == 2);
        take = 0;
        case (m_phase)
            1: if (fe || m_pfe || song_end) begin
                take = 1; m_pfe = 0; m_lane = 0; m_phase = 2; m_endp = song_end;
            end
            2: begin
                if (fe) m_pfe = 1;
                if (song_end) m_endreq = 1;
                commit_lane(m_lane);
                if (m_lane == 3) begin
                    if (m_endp) m_phase = 3;
                    else if (m_pfe || m_endreq) begin
                        take = 1; m_endp = m_endreq; m_endreq = 0; m_pfe = 0; m_lane = 0;
                    end else m_phase = 1;
                end else m_lane++;
            end
            default: take = fe;
        endcase
        for (int l = 0; l < 4; l++) begin
            if (take) begin
                snap_h[l] = live_h[l]; snap_m[l] = live_m[l];
                live_h[l] = 0; live_m[l] = 0;
            end
            if (counting && hit_evt[l] && live_h[l] < 15) live_h[l]++;
            if (counting && miss_evt[l] && live_m[l] < 15) live_m[l]++;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        #2;
        start = 0; song_end = 0; hit_evt = '0; miss_evt = '0;
    endtask

    task automatic hits(int lane, int n);
        repeat (n) begin hit_evt[lane] = 1'b1; tick(); end
    endtask

    task automatic misses(int lane, int n);
        repeat (n) begin miss_evt[lane] = 1'b1; tick(); end
    endtask

    // Rising frame edge followed by the four commit cycles.
    task automatic frame();
        frame_clk = 1; tick();
        frame_clk = 0; repeat (4) tick();
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("score", score, m_score);
                chk("combo", combo, m_combo);
                chk("max_combo", max_combo, m_max);
                chk("mult", mult, m_mult);
                chk("phase", phase, m_phase);
                chk("busy", busy, (m_phase == 2) ? 1 : 0);
            end
        end
    end

    initial begin
        int fcnt;
        model_clear(); m_phase = 0; m_fprev = 0;
        reset = 1; tick(); chk_en = 1; tick(); reset = 0;
        chk("rst_score", score, 0); chk("rst_combo", combo, 0); chk("rst_mult", mult, 1);
        chk("rst_phase", phase, 0); chk("rst_busy", busy, 0);

        // Basic commit
        start = 1; tick();
        hits(0, 3); hits(2, 2);
        frame_clk = 1; tick(); frame_clk = 0;
        chk("basic_busy", busy, 1);
        repeat (4) tick();
        chk("basic_score", score, 50); chk("basic_combo", combo, 5);
        chk("basic_mult", mult, 1); chk("basic_phase", phase, 1);

        // Floor clamp, max_combo retained
        misses(1, 15); frame();
        chk("clamp_score", score, 0); chk("clamp_max", max_combo, 5);
        misses(1, 2); frame();
        chk("floor_score", score, 0); chk("floor_combo", combo, 0);
        chk("floor_max", max_combo, 5);

        // Multiplier
        start = 1; tick();
        hits(1, 9); frame();
        chk("m9_score", score, 90); chk("m9_combo", combo, 9); chk("m9_mult", mult, 1);
        hits(0, 4); frame();
        chk("m13_score", score, 130); chk("m13_combo", combo, 13); chk("m13_mult", mult, 2);
        hits(0, 1); frame();
        chk("m14_score", score, 150);

        // Counter saturation at 15
        hits(3, 20); frame();
        chk("sat_score", score, 450); chk("sat_combo", combo, 29); chk("sat_mult", mult, 3);

        // Hit on the snapshot cycle lands in the next window
        hit_evt[0] = 1; frame();
        chk("snapcyc_score", score, 450);
        frame();
        chk("nextwin_score", score, 480); chk("nextwin_mult", mult, 4);

        // Second frame edge during commit is serviced after lane 3
        hits(0, 2);
        frame_clk = 1; tick();
        frame_clk = 0; hit_evt[1] = 1; tick();
        frame_clk = 1; tick();
        frame_clk = 0; tick(); tick();
        chk("pend_busy", busy, 1);
        chk("pend_first", score, 560);
        repeat (4) tick();
        chk("pend_score", score, 600); chk("pend_combo", combo, 33); chk("pend_phase", phase, 1);

        // Song end with pending hits
        hits(2, 2);
        song_end = 1; tick();
        repeat (4) tick();
        chk("end_score", score, 680); chk("end_phase", phase, 3);
        hits(0, 3); frame();
        chk("done_score", score, 680);
        start = 1; tick();
        chk("restart_score", score, 0); chk("restart_phase", phase, 1);

        // Randomized traffic
        fcnt = 3;
        for (int i = 0; i < 5000; i++) begin
            reset    = ($urandom_range(0, 799) == 0);
            start    = ($urandom_range(0, 399) == 0);
            song_end = ($urandom_range(0, 119) == 0);
            hit_evt  = 4'($urandom) & 4'($urandom);
            miss_evt = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (fcnt == 0) begin
                frame_clk = ~frame_clk; fcnt = $urandom_range(2, 9);
            end else fcnt--;
            tick();
        end
        reset = 0;
        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
